// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the uart_tx_mmio transmitter: FSM encodings, IO page slot numbers
// and the baud divisor helper.
package uart_tx_mmio_pkg;

  typedef enum logic [1:0] {
    UART_S_IDLE  = 2'd0,
    UART_S_START = 2'd1,
    UART_S_DATA  = 2'd2,
    UART_S_STOP  = 2'd3
  } uart_state_e;

  localparam int IO_UART_DAT_bit    = 1;
  localparam int IO_UART_CNTL_bit   = 2;
  localparam int UART_CNTL_BUSY_BIT = 9;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering CPU stores ahead of the UART shifter.
// DEPTH must be a power of two; push while full and pop while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter fed by CPU stores to IO_UART_DAT; tx_busy feeds IO_UART_CNTL bit 9.
// Define UART_TX_FIFO_EN to buffer stores in uart_tx_fifo; the default build uses one shift register.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_wstrb,
  input  logic [7:0] tx_wdata,
  output logic       tx_busy,
  output logic       tx_out
);

  localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  if (DIV < 2 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("uart_tx_mmio: DIV and FIFO_DEPTH must both be at least 2");
  end

  uart_state_e   r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx_out;
  logic          r_tx_busy;

  logic          w_accept;
  logic          w_tick;
  logic          w_stop_end;
  logic          w_start_now;
  logic [7:0]    w_start_data;

  assign w_accept   = tx_wstrb & ~r_tx_busy;
  assign w_tick     = (r_baud_cnt == '0);
  assign w_stop_end = (r_state == UART_S_STOP) & w_tick;
  assign tx_out     = r_tx_out;
  assign tx_busy    = r_tx_busy;

`ifdef UART_TX_FIFO_EN
  localparam int HW = $clog2(FIFO_DEPTH + 1);

  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_fifo_data;
  logic [HW-1:0] r_held;
  logic [HW-1:0] w_held_next;

  // A store into an idle transmitter with nothing queued skips the FIFO so the start bit is immediate.
  assign w_push       = w_accept & ~w_fifo_full & ~((r_state == UART_S_IDLE) & w_fifo_empty);
  assign w_pop        = ~w_fifo_empty & ((r_state == UART_S_IDLE) | w_stop_end);
  assign w_start_now  = w_pop | ((r_state == UART_S_IDLE) & w_accept & w_fifo_empty);
  assign w_start_data = w_pop ? w_fifo_data : tx_wdata;

  // Bytes held counts the queue plus the byte on the wire; the CPU is stalled once it reaches FIFO_DEPTH.
  assign w_held_next  = r_held + HW'(w_accept) - HW'(w_stop_end);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (tx_wdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_held <= '0;
    else         r_held <= w_held_next;
  end
`else
  assign w_start_now  = (r_state == UART_S_IDLE) & w_accept;
  assign w_start_data = tx_wdata;
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= UART_S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx_out   <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
`ifdef UART_TX_FIFO_EN
      r_tx_busy <= (w_held_next >= HW'(FIFO_DEPTH));
`else
      if (w_start_now)     r_tx_busy <= 1'b1;
      else if (w_stop_end) r_tx_busy <= 1'b0;
`endif
      case (r_state)
        UART_S_IDLE: begin
          if (w_start_now) begin
            r_state    <= UART_S_START;
            r_baud_cnt <= BAUD_LAST;
            r_shift    <= w_start_data;
            r_tx_out   <= 1'b0;
          end
        end
        UART_S_START: begin
          if (w_tick) begin
            r_state    <= UART_S_DATA;
            r_baud_cnt <= BAUD_LAST;
            r_bit_idx  <= '0;
            r_tx_out   <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        UART_S_DATA: begin
          if (w_tick) begin
            r_baud_cnt <= BAUD_LAST;
            if (r_bit_idx == 3'd7) begin
              r_state  <= UART_S_STOP;
              r_tx_out <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx_out  <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        UART_S_STOP: begin
          if (w_tick) begin
            if (w_start_now) begin
              r_state    <= UART_S_START;
              r_baud_cnt <= BAUD_LAST;
              r_shift    <= w_start_data;
              r_tx_out   <= 1'b0;
            end else begin
              r_state <= UART_S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        default: r_state <= UART_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at DIV=8 (CLK_FREQ_HZ=8, BAUD_RATE=1).
// Compile with UART_TX_FIFO_EN defined to exercise the buffered variant.
module tb_uart_tx_mmio;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_wstrb = 1'b0;
  logic [7:0] tx_wdata = 8'h00;
  logic       tx_busy;
  logic       tx_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic       dec_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         dec_err = 0;

  uart_tx_mmio #(
    .CLK_FREQ_HZ (8),
    .BAUD_RATE   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_wstrb (tx_wstrb),
    .tx_wdata (tx_wdata),
    .tx_busy  (tx_busy),
    .tx_out   (tx_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit near the middle of its 8-clock slot.
  initial begin : decoder
    logic [7:0] b;
    int         t0;
    forever begin
      @(posedge clk); #1;
      if (dec_en && tx_out === 1'b0) begin
        t0 = cyc;
        repeat (3) @(posedge clk);
        #1;
        if (tx_out !== 1'b0) dec_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(posedge clk);
          #1;
          b[i] = tx_out;
        end
        repeat (8) @(posedge clk);
        #1;
        if (tx_out !== 1'b1) dec_err++;
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    tx_wstrb = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  // Called just after edge N; returns just after edge N+1, where the byte has been sampled.
  task automatic send(input logic [7:0] b);
    tx_wdata = b;
    tx_wstrb = 1'b1;
    tick();
    tx_wstrb = 1'b0;
  endtask

  // Walks the 80 clocks of a frame starting just after edge N+1, then checks the line just after N+81.
  task automatic check_frame(input logic [9:0] exp, input string name, input int inj_cyc,
                             input logic [7:0] inj_data, input logic exp_busy);
    int   bad;
    int   bad_busy;
    logic act;
    bad_busy = 0;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      act = tx_out;
      for (int c = 0; c < 8; c++) begin
        if (tx_out !== exp[k]) begin
          bad++;
          act = tx_out;
        end
        if (tx_busy !== exp_busy) bad_busy++;
        if (k * 8 + c == inj_cyc) begin
          tx_wdata = inj_data;
          tx_wstrb = 1'b1;
        end else if (k * 8 + c == inj_cyc + 1) begin
          tx_wstrb = 1'b0;
        end
        tick();
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s slot %0d: tx_out=%b in %0d clocks, expected %b", name, k, act, bad, exp[k]);
      end
    end
    n_tests++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL %s busy during frame: wrong in %0d clocks, expected %b", name, bad_busy, exp_busy);
    end
    n_tests++;
    if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame end: busy=%b tx_out=%b, expected busy=0 tx_out=1", name, tx_busy, tx_out);
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_tests++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b tx_out=%b, expected 0/1", tx_busy, tx_out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d of 20 clocks not idle, expected 0", bad);
    end
  endtask

  task automatic test_single_frame();
    logic exp_busy;
`ifdef UART_TX_FIFO_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    send(8'h61);
    n_tests++;
    if (tx_busy !== exp_busy || tx_out !== 1'b0) begin
      n_fail++;
      $display("FAIL write_latency: busy=%b tx_out=%b at N+1, expected %b/0", tx_busy, tx_out, exp_busy);
    end
    // 0x61 on the wire, start bit first: 0,1,0,0,0,0,1,1,0,1
    check_frame(10'b1011000010, "frame_0x61", -10, 8'h00, exp_busy);
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_drop_while_busy();
    int bad;
    send(8'h61);
    check_frame(10'b1011000010, "drop_0x62", 2, 8'h62, 1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL drop_no_second_frame: %0d non-idle clocks, expected 0", bad);
    end
  endtask
`endif

`ifdef UART_TX_FIFO_EN
  task automatic test_back_to_back();
    int w;
    rx_q.delete();
    rx_t.delete();
    dec_err = 0;
    dec_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_wdata = 8'h41 + 8'(i);
      tx_wstrb = 1'b1;
      tick();
      if (i == 2) begin
        n_tests++;
        if (tx_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL fifo_not_full_after_3: busy=%b, expected 0", tx_busy);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (tx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL fifo_full_after_4: busy=%b, expected 1", tx_busy);
        end
      end
    end
    tx_wstrb = 1'b0;
    w = 0;
    while (w < 500) begin
      tick();
      w++;
    end
    dec_en = 1'b0;
    n_tests++;
    if (rx_q.size() != 4) begin
      n_fail++;
      $display("FAIL fifo_frame_count: got %0d frames, expected 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rx_q[i] !== 8'h41 + 8'(i)) begin
          n_fail++;
          $display("FAIL fifo_byte_%0d: got %h, expected %h", i, rx_q[i], 8'h41 + 8'(i));
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (rx_t[i + 1] - rx_t[i] != 80) begin
          n_fail++;
          $display("FAIL fifo_gap_%0d: start spacing %0d clocks, expected 80", i, rx_t[i + 1] - rx_t[i]);
        end
      end
    end
    n_tests++;
    if (dec_err != 0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_framing: decoder errors %0d busy=%b, expected 0/0", dec_err, tx_busy);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int bad;
    send(8'h55);
    repeat (30) tick();
    resetn = 1'b0;
    tick();
    n_tests++;
    if (tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_tx_out: tx_out=%b, expected 1", tx_out);
    end
    n_tests++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: busy=%b, expected 0", tx_busy);
    end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_no_resume: %0d non-idle clocks, expected 0", bad);
    end
    send(8'hA3);
`ifdef UART_TX_FIFO_EN
    check_frame({1'b1, 8'hA3, 1'b0}, "after_reset_0xA3", -10, 8'h00, 1'b0);
`else
    check_frame({1'b1, 8'hA3, 1'b0}, "after_reset_0xA3", -10, 8'h00, 1'b1);
`endif
  endtask

  task automatic test_string();
    logic [7:0] msg [28];
    int         w;
    for (int i = 0; i < 26; i++) msg[i] = 8'h61 + 8'(i);
    msg[26] = 8'h0D;
    msg[27] = 8'h0A;
    rx_q.delete();
    rx_t.delete();
    dec_err = 0;
    dec_en  = 1'b1;
    for (int i = 0; i < 28; i++) begin
      w = 0;
      while (tx_busy !== 1'b0 && w < 200) begin
        tick();
        w++;
      end
      n_tests++;
      if (w >= 200) begin
        n_fail++;
        $display("FAIL string_poll_%0d: busy stuck at %b, expected 0 within 200 clocks", i, tx_busy);
      end
      send(msg[i]);
    end
    w = 0;
    while (rx_q.size() < 28 && w < 300) begin
      tick();
      w++;
    end
    repeat (100) tick();
    dec_en = 1'b0;
    n_tests++;
    if (rx_q.size() != 28 || dec_err != 0) begin
      n_fail++;
      $display("FAIL string_count: got %0d bytes with %0d framing errors, expected 28/0", rx_q.size(), dec_err);
    end else begin
      for (int i = 0; i < 28; i++) begin
        n_tests++;
        if (rx_q[i] !== msg[i]) begin
          n_fail++;
          $display("FAIL string_byte_%0d: got %h, expected %h", i, rx_q[i], msg[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
`ifndef UART_TX_FIFO_EN
    test_drop_while_busy();
`else
    test_back_to_back();
`endif
    test_reset_mid_frame();
    test_string();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
